// File: rtl/pre_if_stage_if.sv
// rtl/pre_if_stage_if.sv - SRAM-like instruction fetch port between pre-IF and memory
interface pre_if_stage_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_wdata, inst_sram_addr,
        input  inst_sram_addr_ok
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_wdata, inst_sram_addr,
        output inst_sram_addr_ok
    );
endinterface

// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - pre-IF stage: fetch PC, next-PC selection, fetch request and IF handoff
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fs_allowin,
    output logic                  to_fs_valid,
    output logic [33:0]           to_fs_bus,
    input  logic                  br_stall,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  flush,
    input  logic [31:0]           flush_target,
    pre_if_stage_if.master        sram
);

    logic [31:0] pc_r;
    logic        req_hold;
    logic        hold_cancel;
    logic        redir_pend;
    logic        pend_flush;
    logic [31:0] redir_target;
    logic        buf_valid;
    logic [33:0] buf_bus;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] next_pc;
    logic        start;
    logic        start_adef;
    logic        req;
    logic [31:0] addr;
    logic        accept;
    logic        held_cancel;
    logic        new_valid;
    logic [33:0] new_bus;
    logic [33:0] buf_out;

    assign redir     = flush | br_taken;
    assign redir_tgt = flush ? flush_target : br_target;

    always_comb begin
        next_pc = pc_r + 32'd4;
        if (flush)
            next_pc = flush_target;
        else if (br_taken)
            next_pc = br_target;
        else if (redir_pend)
            next_pc = redir_target;
    end

    assign start      = !reset && !req_hold && !buf_valid && fs_allowin && !br_stall;
    assign start_adef = start && (next_pc[1:0] != 2'b00);
    assign req        = !reset && (req_hold || (start && !start_adef));
    // A held request keeps its address; pc_r was latched when it started.
    assign addr       = req_hold ? pc_r : next_pc;
    assign accept     = req && sram.inst_sram_addr_ok;

    // Only a held request can be overtaken by a redirect; a fresh start already used it.
    assign held_cancel = req_hold && (hold_cancel || redir);
    assign new_valid   = accept || start_adef;
    assign new_bus     = {held_cancel, start_adef, addr};
    assign buf_out     = {buf_bus[33] | redir, buf_bus[32:0]};

    assign to_fs_valid = !reset && (buf_valid || new_valid);
    assign to_fs_bus   = reset ? 34'd0 : (buf_valid ? buf_out : new_bus);

    assign sram.inst_sram_req   = req;
    assign sram.inst_sram_addr  = addr;
    assign sram.inst_sram_wr    = 1'b0;
    assign sram.inst_sram_size  = 2'b10;
    assign sram.inst_sram_wstrb = 4'd0;
    assign sram.inst_sram_wdata = 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC - 32'd4;
            req_hold     <= 1'b0;
            hold_cancel  <= 1'b0;
            redir_pend   <= 1'b0;
            pend_flush   <= 1'b0;
            redir_target <= 32'd0;
            buf_valid    <= 1'b0;
            buf_bus      <= 34'd0;
        end else begin
            if (start)
                pc_r <= next_pc;

            req_hold    <= req && !sram.inst_sram_addr_ok;
            hold_cancel <= req_hold && !sram.inst_sram_addr_ok && (hold_cancel || redir);

            // An unconsumed redirect is remembered; a pending flush outranks a later branch.
            if (start) begin
                redir_pend <= 1'b0;
            end else if (redir && !(redir_pend && pend_flush && !flush)) begin
                redir_pend   <= 1'b1;
                redir_target <= redir_tgt;
                pend_flush   <= flush;
            end

            if (buf_valid) begin
                if (fs_allowin)
                    buf_valid <= 1'b0;
                else if (redir)
                    buf_bus[33] <= 1'b1;
            end else if (new_valid && !fs_allowin) begin
                buf_valid <= 1'b1;
                buf_bus   <= new_bus;
            end
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// tb/tb_pre_if_stage.sv - directed table-driven bench for pre_if_stage
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic [33:0] to_fs_bus;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_target;

    pre_if_stage_if sram ();

    pre_if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk          (clk),
        .reset        (reset),
        .fs_allowin   (fs_allowin),
        .to_fs_valid  (to_fs_valid),
        .to_fs_bus    (to_fs_bus),
        .br_stall     (br_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .flush        (flush),
        .flush_target (flush_target),
        .sram         (sram)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, alw, stl, bt;
        logic [31:0] btg;
        logic        fl;
        logic [31:0] ftg;
        logic        ok;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [33:0] e_bus;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   passed = 0;

    function automatic logic [33:0] fb(input logic c, input logic a, input logic [31:0] pc);
        return {c, a, pc};
    endfunction

    task automatic v(input logic rst, input logic alw, input logic stl, input logic bt,
                     input logic [31:0] btg, input logic fl, input logic [31:0] ftg,
                     input logic ok, input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [33:0] e_bus);
        vec_t r;
        r.rst = rst; r.alw = alw; r.stl = stl; r.bt = bt; r.btg = btg;
        r.fl = fl; r.ftg = ftg; r.ok = ok; r.e_req = e_req; r.e_addr = e_addr;
        r.e_v = e_v; r.e_bus = e_bus;
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic alw, input logic stl, input logic bt,
                         input logic [31:0] btg, input logic fl, input logic [31:0] ftg,
                         input logic ok);
        reset = rst; fs_allowin = alw; br_stall = stl; br_taken = bt; br_target = btg;
        flush = fl; flush_target = ftg; sram.inst_sram_addr_ok = ok;
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic e_req,
                                 input logic [31:0] e_addr, input logic e_v,
                                 input logic [33:0] e_bus, input logic rst);
        chk({tag, "_req"}, idx, {39'd0, sram.inst_sram_req}, {39'd0, e_req});
        if (e_req)
            chk({tag, "_addr"}, idx, {8'd0, sram.inst_sram_addr}, {8'd0, e_addr});
        chk({tag, "_valid"}, idx, {39'd0, to_fs_valid}, {39'd0, e_v});
        if (e_v || rst)
            chk({tag, "_bus"}, idx, {6'd0, to_fs_bus}, {6'd0, e_bus});
    endtask

    localparam logic [31:0] B = 32'h1c000000;

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        //  rst alw stl bt  btg            fl  ftg             ok   req  addr          v    bus
        v(1, 1, 0, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(1, 1, 0, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B,            1, fb(0, 0, B));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 4,        1, fb(0, 0, B + 4));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 8,        1, fb(0, 0, B + 8));
        // held request overtaken by a branch
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 12,       0, 34'd0);
        v(0, 1, 0, 1, B + 32'h100,  0, 0,            0,   1, B + 12,       0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 12,       0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 12,       1, fb(1, 0, B + 12));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h100,  1, fb(0, 0, B + 32'h100));
        // flush in the same cycle the held request is accepted
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h104,  0, 34'd0);
        v(0, 1, 0, 0, 0,            1, B + 32'ha000, 1,   1, B + 32'h104,  1, fb(1, 0, B + 32'h104));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'ha000, 1, fb(0, 0, B + 32'ha000));
        // flush beats branch, nothing outstanding
        v(0, 1, 0, 1, B + 32'h200,  1, B + 32'h8000, 1,   1, B + 32'h8000, 1, fb(0, 0, B + 32'h8000));
        // pending flush not overwritten by later branch
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h8004, 0, 34'd0);
        v(0, 1, 0, 0, 0,            1, B + 32'hc000, 0,   1, B + 32'h8004, 0, 34'd0);
        v(0, 1, 0, 1, B + 32'h300,  0, 0,            0,   1, B + 32'h8004, 0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h8004, 1, fb(1, 0, B + 32'h8004));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'hc000, 1, fb(0, 0, B + 32'hc000));
        // misaligned branch target -> ADEF entry, no request
        v(0, 1, 0, 1, B + 32'h102,  0, 0,            1,   0, 0,            1, fb(0, 1, B + 32'h102));
        v(0, 1, 0, 0, 0,            1, B + 32'h400,  1,   1, B + 32'h400,  1, fb(0, 0, B + 32'h400));
        // accept while IF is blocked -> buffered entry
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h404,  0, 34'd0);
        v(0, 0, 0, 0, 0,            0, 0,            0,   1, B + 32'h404,  0, 34'd0);
        v(0, 0, 0, 0, 0,            0, 0,            1,   1, B + 32'h404,  1, fb(0, 0, B + 32'h404));
        v(0, 0, 0, 0, 0,            0, 0,            1,   0, 0,            1, fb(0, 0, B + 32'h404));
        v(0, 0, 0, 0, 0,            0, 0,            1,   0, 0,            1, fb(0, 0, B + 32'h404));
        v(0, 1, 0, 0, 0,            0, 0,            1,   0, 0,            1, fb(0, 0, B + 32'h404));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h408,  1, fb(0, 0, B + 32'h408));
        // redirect while buffered cancels the buffered entry
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h40c,  0, 34'd0);
        v(0, 0, 0, 0, 0,            0, 0,            1,   1, B + 32'h40c,  1, fb(0, 0, B + 32'h40c));
        v(0, 0, 0, 1, B + 32'h500,  0, 0,            1,   0, 0,            1, fb(1, 0, B + 32'h40c));
        v(0, 1, 0, 0, 0,            0, 0,            1,   0, 0,            1, fb(1, 0, B + 32'h40c));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h500,  1, fb(0, 0, B + 32'h500));
        // branch stall with nothing held
        v(0, 1, 1, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 1, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 1, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 1, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h504,  1, fb(0, 0, B + 32'h504));
        // branch stall raised while a request is held
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h508,  0, 34'd0);
        v(0, 1, 1, 0, 0,            0, 0,            0,   1, B + 32'h508,  0, 34'd0);
        v(0, 1, 1, 0, 0,            0, 0,            1,   1, B + 32'h508,  1, fb(0, 0, B + 32'h508));
        v(0, 1, 1, 0, 0,            0, 0,            1,   0, 0,            0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B + 32'h50c,  1, fb(0, 0, B + 32'h50c));
        // reset drops held request and pending redirect
        v(0, 1, 0, 0, 0,            0, 0,            0,   1, B + 32'h510,  0, 34'd0);
        v(0, 1, 0, 0, 0,            1, B + 32'hf000, 0,   1, B + 32'h510,  0, 34'd0);
        v(1, 1, 0, 0, 0,            0, 0,            0,   0, 0,            0, 34'd0);
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, B,            1, fb(0, 0, B));
        // PC adder wraps
        v(0, 1, 0, 0, 0,            1, 32'hfffffffc, 1,   1, 32'hfffffffc, 1, fb(0, 0, 32'hfffffffc));
        v(0, 1, 0, 0, 0,            0, 0,            1,   1, 32'h00000000, 1, fb(0, 0, 32'h0));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].alw, vq[i].stl, vq[i].bt, vq[i].btg, vq[i].fl, vq[i].ftg, vq[i].ok);
            #1;
            check_outputs("vec", i, vq[i].e_req, vq[i].e_addr, vq[i].e_v, vq[i].e_bus, vq[i].rst);
        end

        chk("const_port", 0,
            {1'b0, sram.inst_sram_wr, sram.inst_sram_size, sram.inst_sram_wstrb, sram.inst_sram_wdata},
            {1'b0, 1'b0, 2'b10, 4'd0, 32'd0});

        // Long hold: address frozen while IF readiness and stall toggle underneath it.
        @(negedge clk);
        drive(0, 1, 0, 0, 32'd0, 0, 32'd0, 0);
        #1;
        check_outputs("hold_start", 0, 1'b1, 32'h4, 1'b0, 34'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, k[0], ~k[0], 0, 32'd0, 0, 32'd0, 0);
            #1;
            check_outputs("hold_frozen", k, 1'b1, 32'h4, 1'b0, 34'd0, 1'b0);
        end
        @(negedge clk);
        drive(0, 1, 0, 0, 32'd0, 0, 32'd0, 1);
        #1;
        check_outputs("hold_accept", 0, 1'b1, 32'h4, 1'b1, fb(0, 0, 32'h4), 1'b0);
        @(negedge clk);
        #1;
        check_outputs("hold_next", 0, 1'b1, 32'h8, 1'b1, fb(0, 0, 32'h8), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
